apu_frame_counter: RTL and testbench
====================================

# apu_frame_counter

Frame sequencer for the APU. It divides the CPU clock-enable stream into the quarter-frame and half-frame clock enables that drive the envelope, linear-counter, length-counter and sweep units of every channel, including the triangle channel. It decodes CPU writes to $4017 for mode and IRQ-inhibit, applies the write-triggered sequencer reset, and maintains the frame-IRQ flag that is read and cleared through $4015.

## Interface
Parameters: none (step constants live in `apu_pkg`).

- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `cpu_clk_en` input 1: one-`clk` pulse per CPU cycle. All state advances only when this is high.
- `addr` input 16: CPU bus address.
- `data_in` input 8: CPU write data.
- `we` input 1: CPU write strobe, qualified by `cpu_clk_en`.
- `re` input 1: CPU read strobe, qualified by `cpu_clk_en`.
- `quarter_clk_en` output 1: quarter-frame pulse, high in a `cpu_clk_en` cycle only.
- `half_clk_en` output 1: half-frame pulse, high in a `cpu_clk_en` cycle only.
- `frame_irq` output 1: frame interrupt flag (level), fed to $4015 bit 6 and to the CPU IRQ OR.
- `mode` output 1: 0 selects 4-step, 1 selects 5-step.

## Operation
**State**
- `count`: 16-bit cycle counter.
- `mode`, `irq_inhibit`.
- `irq_flag`.
- `parity`: toggles on every `cpu_clk_en`.
- `rst_pend` plus a 3-bit `rst_delay`.
- `wrapped`: set when `count` wraps to 0, cleared on a write-triggered reset.

**Counter.** On each `cpu_clk_en`, `count` increments. When `count` reaches period−1, it loads 0 instead.
- 4-step period: 29830.
- 5-step period: 37282.

**4-step events** (`mode`=0), decoded when `count` equals:
- 7457: Q.
- 14913: Q+H.
- 22371: Q.
- 29828: IRQ set.
- 29829: Q+H and IRQ set.
- 0 with `wrapped`=1: IRQ set.

**5-step events** (`mode`=1), decoded when `count` equals:
- 7457: Q.
- 14913: Q+H.
- 22371: Q.
- 37281: Q+H.
- IRQ is never set in 5-step mode.

**Outputs.**
- Q means `quarter_clk_en` is high. H means `half_clk_en` is high.
- Both are combinational decodes of `count`/`mode` ANDed with `cpu_clk_en`. They are forced to 0 while `rst` is high.

**IRQ set.** "IRQ set" takes effect only when `irq_inhibit`=0. `irq_flag` becomes 1 on the following `clk`.

**$4017 write** (`we` and `cpu_clk_en` and `addr`==16'h4017):
- `mode` ← `data_in[7]` and `irq_inhibit` ← `data_in[6]`, effective next cycle.
- If `data_in[6]`=1, `irq_flag` is cleared.
- `rst_delay` ← 3 if `parity`=0, else 4. `rst_pend` ← 1.

**Pending sequencer reset.**
- Each later `cpu_clk_en` decrements `rst_delay`.
- On the `cpu_clk_en` where `rst_delay`==1: `count` ← 0, `wrapped` ← 0, `rst_pend` ← 0.
- If the new `mode`=1, Q and H are both pulsed in that same cycle.
- Normal event decode continues while a reset is pending.
- A second $4017 write while a reset is pending restarts the delay, using the new parity and values.

**$4015 read** (`re` and `cpu_clk_en` and `addr`==16'h4015):
- `irq_flag` is cleared on the next `clk`. The read itself observes the old value.
- If an IRQ set happens in the same cycle, the set wins and the flag stays 1.

**Priority for `irq_flag` update:** inhibit-write clear > IRQ set > read clear.

**Reset:**
- `count`=0, `mode`=0, `irq_inhibit`=0, `irq_flag`=0, `parity`=0, `rst_pend`=0, `wrapped`=0.
- `quarter_clk_en`=0, `half_clk_en`=0, `frame_irq`=0, `mode` output=0.
- A reset asserted mid-sequence or mid-delay aborts the pending reset and any events.

## Timing
- Pulse latency is zero: Q/H are asserted in the same `clk` as the qualifying `cpu_clk_en`.
- `frame_irq` rises one `clk` after the set event and stays high until cleared.
- From a $4017 write to `count`=0 is exactly 3 or 4 `cpu_clk_en` pulses, selected by the parity at the write.
- The first Q after a sequencer reset occurs 7457 `cpu_clk_en` pulses later.
- Cycles without `cpu_clk_en` change nothing. The only exception is that `rst` acts on any `clk`.

## Structure
- `apu_pkg` holds:
  - the step constants (7457, 14913, 22371, 29828, 29829, 37281);
  - the periods (29830, 37282);
  - `ADDR_FRAME`=16'h4017 and `ADDR_STATUS`=16'h4015.
- One sub-module, `frame_reset_delay`, contains the parity bit, delay counter and pending flag. Its outputs are `seq_reset` (a pulse aligned to `cpu_clk_en`) and `pending`.
- The top level contains the counter, the event decode and the IRQ flag.

## Test plan
- After `rst`, with `cpu_clk_en` every 3rd `clk` → Q at counts 7457/14913/22371/29829, H at 14913/29829, `frame_irq` rises after count 29828, and Q pulses recur with period 29830.
- Write $4017=8'h80 with `parity`=0 → `count`=0 after 3 `cpu_clk_en`, Q+H pulse in that cycle, no IRQ over 2 full frames, 5-step period 37282.
- Repeat the write with `parity`=1 → reset lands after 4 `cpu_clk_en`. A second write during the delay restarts it.
- In 4-step mode with the IRQ pending, $4015 read → flag clears next `clk`. A read coinciding with count 29829 → flag stays 1.
- Write $4017=8'h40 while `frame_irq`=1 → flag clears immediately and no IRQ for 3 frames. Then write 8'h00 → IRQ returns after count 29828.
- Assert `rst` at count 20000 with a reset pending → all outputs 0, no delayed reset fires, and the sequence restarts from count 0.

Source files
------------

// File: rtl/apu_frame_counter_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg
// Shared constants for the APU frame sequencer: step counts at which the
// quarter/half-frame clocks and the frame IRQ are decoded, the sequence
// periods of both modes, the CPU register addresses and the delay lengths
// of the write-triggered sequencer reset.
// Ports: none (package).
// -----------------------------------------------------------------------------
package apu_pkg;

   typedef enum logic {
      MODE_4STEP = 1'b0,
      MODE_5STEP = 1'b1
   } seq_mode_e;

   // Step counts (in CPU cycles since the sequence start)
   localparam logic [15:0] STEP_Q1      = 16'd7457;
   localparam logic [15:0] STEP_Q2H1    = 16'd14913;
   localparam logic [15:0] STEP_Q3      = 16'd22371;
   localparam logic [15:0] STEP_4_IRQ   = 16'd29828;
   localparam logic [15:0] STEP_4_LAST  = 16'd29829;
   localparam logic [15:0] STEP_5_LAST  = 16'd37281;

   localparam logic [15:0] PERIOD_4STEP = 16'd29830;
   localparam logic [15:0] PERIOD_5STEP = 16'd37282;

   localparam logic [15:0] ADDR_FRAME   = 16'h4017;
   localparam logic [15:0] ADDR_STATUS  = 16'h4015;

   // Write-to-reset delay, selected by the CPU cycle parity at the write
   localparam logic [2:0]  DELAY_EVEN   = 3'd3;
   localparam logic [2:0]  DELAY_ODD    = 3'd4;

   function automatic logic [15:0] last_count(input seq_mode_e m);
      return (m == MODE_5STEP) ? (PERIOD_5STEP - 16'd1) : (PERIOD_4STEP - 16'd1);
   endfunction

endpackage

// File: rtl/apu_frame_counter_if.sv
// -----------------------------------------------------------------------------
// apu_frame_counter_if
// CPU bus as seen by the frame sequencer.
//   cpu_clk_en : one-clk pulse per CPU cycle, qualifies we/re
//   addr       : CPU address (16 bits)
//   data_in    : CPU write data (8 bits)
//   we / re    : write / read strobes
// master: CPU side (drives), slave: frame sequencer (receives).
// -----------------------------------------------------------------------------
interface apu_frame_counter_if;
   logic        cpu_clk_en;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic        we;
   logic        re;

   modport master (output cpu_clk_en, addr, data_in, we, re);
   modport slave  (input  cpu_clk_en, addr, data_in, we, re);
endinterface

// File: rtl/apu_frame_counter_frame_reset_delay.sv
// -----------------------------------------------------------------------------
// frame_reset_delay
// Tracks CPU cycle parity and schedules the sequencer reset that follows a
// $4017 write: 3 CPU cycles later when the write lands on an even cycle,
// 4 when odd. A new write while one is pending restarts the delay.
//   clk, rst     : system clock, synchronous active-high reset
//   cpu_clk_en   : CPU cycle enable
//   frame_write  : qualified $4017 write (already ANDed with cpu_clk_en)
//   seq_reset    : one-cycle pulse, aligned to cpu_clk_en, when the delay ends
//   pending      : a sequencer reset is scheduled
// -----------------------------------------------------------------------------
module frame_reset_delay
   import apu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic cpu_clk_en,
   input  logic frame_write,
   output logic seq_reset,
   output logic pending
);

   logic       parity;
   logic [2:0] rst_delay;

   // A write in the same cycle restarts the delay instead of letting it fire.
   assign seq_reset = cpu_clk_en & pending & ~frame_write & (rst_delay == 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         parity    <= 1'b0;
         pending   <= 1'b0;
         rst_delay <= '0;
      end else if (cpu_clk_en) begin
         parity <= ~parity;
         if (frame_write) begin
            rst_delay <= parity ? DELAY_ODD : DELAY_EVEN;
            pending   <= 1'b1;
         end else if (pending) begin
            rst_delay <= rst_delay - 3'd1;
            if (rst_delay == 3'd1) begin
               pending <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/apu_frame_counter.sv
// -----------------------------------------------------------------------------
// apu_frame_counter
// APU frame sequencer: divides the CPU cycle stream into quarter- and
// half-frame clock enables, decodes $4017 (mode / IRQ inhibit, sequencer
// reset) and keeps the frame IRQ flag that $4015 reads clear.
//   clk, rst        : system clock, synchronous active-high reset
//   bus             : CPU bus (cpu_clk_en, addr, data_in, we, re), slave side
//   quarter_clk_en  : quarter-frame pulse, only in cpu_clk_en cycles
//   half_clk_en     : half-frame pulse, only in cpu_clk_en cycles
//   frame_irq       : frame interrupt flag (level)
//   mode            : 0 = 4-step, 1 = 5-step
// -----------------------------------------------------------------------------
module apu_frame_counter
   import apu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   apu_frame_counter_if.slave bus,
   output logic               quarter_clk_en,
   output logic               half_clk_en,
   output logic               frame_irq,
   output logic               mode
);

   logic [15:0] count;
   seq_mode_e   seq_mode;
   logic        irq_inhibit;
   logic        irq_flag;
   logic        wrapped;

   logic        frame_write;
   logic        status_read;
   logic        seq_reset;
   logic        reset_pending;
   logic        seq_fire;
   logic        five_step;
   logic        q_evt;
   logic        h_evt;
   logic        irq_evt;
   logic        irq_set;

   assign five_step   = (seq_mode == MODE_5STEP);
   assign frame_write = bus.cpu_clk_en & bus.we & (bus.addr == ADDR_FRAME);
   assign status_read = bus.cpu_clk_en & bus.re & (bus.addr == ADDR_STATUS);

   frame_reset_delay u_reset_delay (
      .clk         (clk),
      .rst         (rst),
      .cpu_clk_en  (bus.cpu_clk_en),
      .frame_write (frame_write),
      .seq_reset   (seq_reset),
      .pending     (reset_pending)
   );

   // The pending flag qualifies the pulse so a stale delay value never fires.
   assign seq_fire = seq_reset & reset_pending;

   // Step decode of the current count
   always_comb begin
      q_evt   = 1'b0;
      h_evt   = 1'b0;
      irq_evt = 1'b0;
      case (count)
         STEP_Q1:     q_evt = 1'b1;
         STEP_Q2H1: begin
            q_evt = 1'b1;
            h_evt = 1'b1;
         end
         STEP_Q3:     q_evt = 1'b1;
         STEP_4_IRQ:  irq_evt = ~five_step;
         STEP_4_LAST: begin
            q_evt   = ~five_step;
            h_evt   = ~five_step;
            irq_evt = ~five_step;
         end
         STEP_5_LAST: begin
            q_evt = five_step;
            h_evt = five_step;
         end
         16'd0:       irq_evt = ~five_step & wrapped;
         default: ;
      endcase
   end

   assign irq_set = bus.cpu_clk_en & irq_evt & ~irq_inhibit;

   // A sequencer reset in 5-step mode clocks both units immediately.
   assign quarter_clk_en = ~rst & bus.cpu_clk_en & (q_evt | (seq_fire & five_step));
   assign half_clk_en    = ~rst & bus.cpu_clk_en & (h_evt | (seq_fire & five_step));
   assign frame_irq      = irq_flag;
   assign mode           = five_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         wrapped     <= 1'b0;
         seq_mode    <= MODE_4STEP;
         irq_inhibit <= 1'b0;
         irq_flag    <= 1'b0;
      end else if (bus.cpu_clk_en) begin
         if (seq_fire) begin
            count   <= '0;
            wrapped <= 1'b0;
         end else if (count == last_count(seq_mode)) begin
            count   <= '0;
            wrapped <= 1'b1;
         end else begin
            count <= count + 16'd1;
         end

         if (frame_write) begin
            seq_mode    <= seq_mode_e'(bus.data_in[7]);
            irq_inhibit <= bus.data_in[6];
         end

         // inhibit-write clear > IRQ set > status-read clear
         if (frame_write && bus.data_in[6]) begin
            irq_flag <= 1'b0;
         end else if (irq_set) begin
            irq_flag <= 1'b1;
         end else if (status_read) begin
            irq_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_apu_frame_counter.sv
// -----------------------------------------------------------------------------
// tb_apu_frame_counter
// Self-checking bench for apu_frame_counter. Outputs are compared every
// cycle against a reference model that tracks the sequence position, the
// absolute CPU-cycle index at which a scheduled reset lands, and the IRQ
// flag, plus directed checks at the interesting steps.
// -----------------------------------------------------------------------------
module tb_apu_frame_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic quarter_clk_en;
   logic half_clk_en;
   logic frame_irq;
   logic mode;

   apu_frame_counter_if bus_if ();

   apu_frame_counter dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus_if),
      .quarter_clk_en (quarter_clk_en),
      .half_clk_en    (half_clk_en),
      .frame_irq      (frame_irq),
      .mode           (mode)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference model state
   int unsigned m_pos     = 0;   // CPU cycles since sequence start
   int unsigned m_n_en    = 0;   // CPU cycles since rst (parity = bit 0)
   int unsigned m_fire_at = 0;   // CPU cycle index at which a pending reset lands
   bit          m_pend    = 1'b0;
   bit          m_mode    = 1'b0;
   bit          m_inh     = 1'b0;
   bit          m_flag    = 1'b0;
   bit          m_wrapped = 1'b0;

   // DUT outputs as sampled during the most recent cycle
   logic last_q, last_h, last_irq, last_mode;

   function automatic bit quarter_due(input int unsigned pos, input bit five);
      int unsigned last;
      last = five ? 37281 : 29829;
      return (pos == 7457) || (pos == 14913) || (pos == 22371) || (pos == last);
   endfunction

   function automatic bit half_due(input int unsigned pos, input bit five);
      int unsigned last;
      last = five ? 37281 : 29829;
      return (pos == 14913) || (pos == last);
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b (t=%0t pos=%0d)", tag, obs, exp, $time, m_pos);
      end
   endtask

   // One clk cycle: drive inputs, check outputs mid-cycle, advance the model.
   task automatic cyc(input bit r, input bit en, input logic [15:0] a,
                      input logic [7:0] d, input bit w, input bit rd_s);
      bit wr, rd, fire, exp_q, exp_h, irq_set;
      int unsigned period;
      rst               = r;
      bus_if.cpu_clk_en = en;
      bus_if.addr       = a;
      bus_if.data_in    = d;
      bus_if.we         = w;
      bus_if.re         = rd_s;
      @(negedge clk);
      wr   = en && w && (a == 16'h4017);
      rd   = en && rd_s && (a == 16'h4015);
      fire = en && m_pend && !wr && (m_n_en == m_fire_at);
      exp_q = !r && en && (quarter_due(m_pos, m_mode) || (fire && m_mode));
      exp_h = !r && en && (half_due(m_pos, m_mode) || (fire && m_mode));
      last_q    = quarter_clk_en;
      last_h    = half_clk_en;
      last_irq  = frame_irq;
      last_mode = mode;
      check("quarter", quarter_clk_en, exp_q);
      check("half", half_clk_en, exp_h);
      check("frame_irq", frame_irq, m_flag);
      check("mode", mode, m_mode);
      if (r) begin
         m_pos = 0; m_n_en = 0; m_fire_at = 0; m_pend = 0;
         m_mode = 0; m_inh = 0; m_flag = 0; m_wrapped = 0;
      end else if (en) begin
         irq_set = !m_mode && !m_inh &&
                   ((m_pos == 29828) || (m_pos == 29829) || ((m_pos == 0) && m_wrapped));
         if (wr && d[6])   m_flag = 1'b0;
         else if (irq_set) m_flag = 1'b1;
         else if (rd)      m_flag = 1'b0;
         period = m_mode ? 37282 : 29830;
         if (fire) begin
            m_pos = 0; m_wrapped = 0; m_pend = 0;
         end else if (m_pos == period - 1) begin
            m_pos = 0; m_wrapped = 1;
         end else begin
            m_pos = (m_pos + 1) % 65536;
         end
         if (wr) begin
            m_mode    = d[7];
            m_inh     = d[6];
            m_pend    = 1'b1;
            m_fire_at = m_n_en + (((m_n_en % 2) == 1) ? 4 : 3);
         end
         m_n_en++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      cyc(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic gap();
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic wr_frame(input logic [7:0] d);
      cyc(1'b0, 1'b1, 16'h4017, d, 1'b1, 1'b0);
   endtask

   task automatic rd_status();
      cyc(1'b0, 1'b1, 16'h4015, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic align_even();
      if ((m_n_en % 2) == 1) pulse();
   endtask

   // Random cycle: mostly-enabled CPU cycles with unrelated bus traffic.
   task automatic random_cycle(input bit allow_rd);
      bit en;
      int unsigned kind;
      en   = ($urandom_range(0, 15) != 0);
      kind = $urandom_range(0, 15);
      case (kind)
         0: cyc(1'b0, 1'b0, 16'h4017, 8'($urandom), 1'b1, 1'b0);
         1: cyc(1'b0, 1'b0, 16'h4015, 8'h00, 1'b0, 1'b1);
         2: cyc(1'b0, en, 16'h4016, 8'($urandom), 1'b1, 1'b0);
         3: cyc(1'b0, en, 16'h4015, 8'($urandom), 1'b1, 1'b0);
         4: cyc(1'b0, en, 16'h4017, 8'h00, 1'b0, 1'b1);
         5: cyc(1'b0, en, 16'h4015, 8'h00, 1'b0, allow_rd);
         default: cyc(1'b0, en, 16'($urandom), 8'($urandom), 1'b0, 1'b0);
      endcase
   endtask

   task automatic run_to(input int unsigned target, input bit allow_rd);
      int unsigned guard;
      guard = 0;
      while ((m_pos != target) && (guard < 90000)) begin
         random_cycle(allow_rd);
         guard++;
      end
      checks++;
      assert (m_pos == target) else begin
         errors++;
         $error("FAIL run_to: reached=%0d required=%0d", m_pos, target);
      end
   endtask

   initial begin
      bus_if.cpu_clk_en = 1'b0;
      bus_if.addr       = '0;
      bus_if.data_in    = '0;
      bus_if.we         = 1'b0;
      bus_if.re         = 1'b0;
      @(posedge clk);
      #1;

      // Reset dominates bus activity
      repeat (3) cyc(1'b1, 1'b1, 16'h4017, 8'hC0, 1'b1, 1'b1);
      check("rst_quarter", last_q, 1'b0);
      check("rst_half", last_h, 1'b0);
      check("rst_irq", last_irq, 1'b0);
      check("rst_mode", last_mode, 1'b0);

      // Odd-parity write: reset lands on the 4th CPU cycle
      pulse();
      wr_frame(8'h80);
      for (int i = 0; i < 3; i++) begin
         pulse();
         check("odd_delay_early", last_q, 1'b0);
      end
      gap();
      gap();
      pulse();
      check("odd_land_quarter", last_q, 1'b1);
      check("odd_land_half", last_h, 1'b1);
      check("mode_after_80", last_mode, 1'b1);

      // Second write during the delay restarts it with the new parity
      align_even();
      wr_frame(8'h80);
      wr_frame(8'h80);
      for (int i = 0; i < 3; i++) begin
         pulse();
         check("restart_no_old", last_q, 1'b0);
      end
      pulse();
      check("restart_land_quarter", last_q, 1'b1);
      check("restart_land_half", last_h, 1'b1);

      // rst during a pending reset aborts it
      align_even();
      wr_frame(8'h80);
      pulse();
      cyc(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         pulse();
         check("abort_quarter", last_q, 1'b0);
         check("abort_half", last_h, 1'b0);
         check("abort_mode", last_mode, 1'b0);
      end

      // 4-step frame, first stretch with cpu_clk_en every 3rd clk
      for (int i = 0; i < 600; i++) begin
         cyc(1'b0, (i % 3) == 0, 16'($urandom), 8'($urandom), 1'b0, 1'b0);
      end
      run_to(7457, 1'b1);
      pulse();
      check("q1_quarter", last_q, 1'b1);
      check("q1_half", last_h, 1'b0);
      run_to(14913, 1'b1);
      pulse();
      check("q2_quarter", last_q, 1'b1);
      check("q2_half", last_h, 1'b1);
      run_to(22371, 1'b1);
      pulse();
      check("q3_quarter", last_q, 1'b1);
      check("q3_half", last_h, 1'b0);
      run_to(29828, 1'b1);
      pulse();
      check("irq_step_quiet", last_q, 1'b0);
      rd_status();
      check("q4_quarter", last_q, 1'b1);
      check("q4_half", last_h, 1'b1);
      check("irq_rise", last_irq, 1'b1);
      pulse();
      check("read_vs_set", last_irq, 1'b1);
      check("wrap_quarter", last_q, 1'b0);
      rd_status();
      check("irq_before_clear", last_irq, 1'b1);
      gap();
      check("read_clear", last_irq, 1'b0);

      // Switch to 5-step with inhibit; run a full 5-step frame
      align_even();
      wr_frame(8'hC0);
      pulse();
      pulse();
      check("five_early", last_q, 1'b0);
      pulse();
      check("five_land_quarter", last_q, 1'b1);
      check("five_land_half", last_h, 1'b1);
      run_to(7457, 1'b1);
      pulse();
      check("five_q1", last_q, 1'b1);
      run_to(37281, 1'b1);
      pulse();
      check("five_last_quarter", last_q, 1'b1);
      check("five_last_half", last_h, 1'b1);
      pulse();
      check("five_wrap_quarter", last_q, 1'b0);
      check("five_no_irq", last_irq, 1'b0);

      // Back to 4-step
      align_even();
      wr_frame(8'h00);
      pulse();
      check("mode_back_4step", last_mode, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
